// File: rtl/fir_filter_param.sv
// fir_filter_param
// Direct-form N-tap FIR with parametrised widths, runtime-loadable
// coefficients, a flush control and an arithmetic output shift.
// Each accepted sample produces exactly one result two cycles later.
//
// Pipeline:
//   edge k   : sample enters the delay line (v0)
//   edge k+1 : per-tap products registered (v1)
//   edge k+2 : products summed, shifted, narrowed, registered (valid_out)
//
// Ports:
//   clk           in   clock, rising edge
//   rst           in   synchronous active-high reset
//   input_signal  in   DATA_W signed sample
//   valid_in      in   sample qualifier
//   flush         in   clears delay line and in-flight samples
//   coef_we       in   coefficient write enable
//   coef_addr     in   ADDR_W tap index for the write
//   coef_data     in   COEF_W signed coefficient
//   output_signal out  OUT_W signed filtered sample
//   valid_out     out  one-cycle qualifier for output_signal
//
// Build option:
//   FIR_SATURATE_EN  clamp the shifted accumulator to the OUT_W signed
//                    range; when undefined the low OUT_W bits are kept.
module fir_filter_param #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int OUT_W  = 16,
  parameter int TAPS   = 8,
  parameter int SHIFT  = 0,
  parameter int ADDR_W = $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] input_signal,
  input  logic                     valid_in,
  input  logic                     flush,
  input  logic                     coef_we,
  input  logic        [ADDR_W-1:0] coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic signed [OUT_W-1:0]  output_signal,
  output logic                     valid_out
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + ADDR_W + 1;

  logic signed [DATA_W-1:0] r_d    [TAPS];
  logic signed [COEF_W-1:0] r_coef [TAPS];
  logic signed [PROD_W-1:0] r_p    [TAPS];
  logic                     r_v0;
  logic                     r_v1;
  logic signed [OUT_W-1:0]  r_out;
  logic                     r_vout;

  logic signed [ACC_W-1:0]  w_acc;
  logic signed [ACC_W-1:0]  w_shift;
  logic signed [OUT_W-1:0]  w_out;

  // Stage 0: delay line
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < TAPS; i++) r_d[i] <= '0;
      r_v0 <= 1'b0;
    end else begin
      r_v0 <= valid_in;
      if (valid_in) begin
        r_d[0] <= input_signal;
        for (int i = 1; i < TAPS; i++) r_d[i] <= r_d[i-1];
      end
    end
  end

  // Coefficient bank. Addresses with no matching tap simply match nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) r_coef[i] <= COEF_W'(1);
    end else if (coef_we) begin
      for (int i = 0; i < TAPS; i++) begin
        if (coef_addr == ADDR_W'(i)) r_coef[i] <= coef_data;
      end
    end
  end

  // Stage 1: products. Computed every cycle; validity travels in r_v1.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) r_p[i] <= '0;
      r_v1 <= 1'b0;
    end else begin
      for (int i = 0; i < TAPS; i++) begin
        r_p[i] <= PROD_W'(r_d[i]) * PROD_W'(r_coef[i]);
      end
      r_v1 <= r_v0 && !flush;
    end
  end

  always_comb begin
    w_acc = '0;
    for (int i = 0; i < TAPS; i++) w_acc = w_acc + ACC_W'(r_p[i]);
  end

  assign w_shift = w_acc >>> SHIFT;

`ifdef FIR_SATURATE_EN
  localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  always_comb begin
    w_out = OUT_W'(w_shift);
    if (w_shift > ACC_W'(OUT_MAX))      w_out = OUT_MAX;
    else if (w_shift < ACC_W'(OUT_MIN)) w_out = OUT_MIN;
  end
`else
  assign w_out = OUT_W'(w_shift);
`endif

  // Stage 2: output register holds its value between valid results.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out  <= '0;
      r_vout <= 1'b0;
    end else begin
      r_vout <= r_v1;
      if (r_v1) r_out <= w_out;
    end
  end

  assign output_signal = r_out;
  assign valid_out     = r_vout;

endmodule

// File: tb/tb_fir_filter_param.sv
module tb_fir_filter_param;

  logic               clk;
  logic               rst;
  logic signed [15:0] input_signal;
  logic               valid_in;
  logic               flush;
  logic               coef_we;
  logic        [1:0]  coef_addr;
  logic signed [15:0] coef_data;
  logic signed [15:0] output_signal;
  logic               valid_out;

  int n_checks = 0;
  int n_pass   = 0;

  fir_filter_param #(
    .DATA_W(16), .COEF_W(16), .OUT_W(16), .TAPS(4), .SHIFT(0)
  ) dut (
    .clk(clk), .rst(rst), .input_signal(input_signal), .valid_in(valid_in),
    .flush(flush), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .output_signal(output_signal), .valid_out(valid_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; valid_in = 1'b0; flush = 1'b0; coef_we = 1'b0;
    coef_addr = '0; coef_data = '0; input_signal = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic write_coef(input int addr, input int val);
    coef_we = 1'b1; coef_addr = 2'(addr); coef_data = 16'(val);
    tick();
    coef_we = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1; valid_in = 1'b1; input_signal = 16'sd77; coef_we = 1'b1;
    tick();
    tick();
    idle();
    n_checks++;
    if (valid_out !== 1'b0) $display("FAIL reset valid_out: got %b expected 0", valid_out);
    else n_pass++;
    n_checks++;
    if (output_signal !== 16'sd0) $display("FAIL reset output: got %0d expected 0", output_signal);
    else n_pass++;
  endtask

  task automatic test_running_sum();
    int samp [5] = '{1, 2, 3, 4, 5};
    int exp_o[5] = '{1, 3, 6, 10, 14};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i < 5) begin valid_in = 1'b1; input_signal = 16'(samp[i]); end
      else begin valid_in = 1'b0; input_signal = '0; end
      tick();
      n_checks++;
      if (valid_out !== ((i >= 2) && (i < 7)))
        $display("FAIL sum valid[%0d]: got %b expected %b", i, valid_out, (i >= 2) && (i < 7));
      else n_pass++;
      if (i >= 2 && i < 7) begin
        n_checks++;
        if (output_signal !== 16'(exp_o[i-2]))
          $display("FAIL sum out[%0d]: got %0d expected %0d", i, output_signal, exp_o[i-2]);
        else n_pass++;
      end
    end
    n_checks++;
    if (output_signal !== 16'sd14) $display("FAIL sum hold: got %0d expected 14", output_signal);
    else n_pass++;
  endtask

  task automatic test_difference();
    int samp [3] = '{5, 7, 7};
    int exp_v[5] = '{0, 0, 1, 1, 1};
    int exp_o[5] = '{0, 0, 5, 2, 0};
    do_reset();
    write_coef(1, -1);
    write_coef(2, 0);
    write_coef(3, 0);
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin valid_in = 1'b1; input_signal = 16'(samp[i]); end
      else begin valid_in = 1'b0; input_signal = '0; end
      tick();
      n_checks++;
      if (valid_out !== 1'(exp_v[i]))
        $display("FAIL diff valid[%0d]: got %b expected %0d", i, valid_out, exp_v[i]);
      else n_pass++;
      n_checks++;
      if (output_signal !== 16'(exp_o[i]))
        $display("FAIL diff out[%0d]: got %0d expected %0d", i, output_signal, exp_o[i]);
      else n_pass++;
    end
  endtask

  task automatic test_saturation();
`ifdef FIR_SATURATE_EN
    int exp_p[4] = '{20000, 32767, 32767, 32767};
    int exp_n[4] = '{-20000, -32768, -32768, -32768};
`else
    int exp_p[4] = '{20000, -25536, -5536, 14464};
    int exp_n[4] = '{-20000, 25536, 5536, -14464};
`endif
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      for (int i = 0; i < 6; i++) begin
        valid_in = (i < 4);
        input_signal = (pass == 0) ? 16'sd20000 : -16'sd20000;
        tick();
        if (i >= 2) begin
          n_checks++;
          if (pass == 0) begin
            if (output_signal !== 16'(exp_p[i-2]))
              $display("FAIL sat pos[%0d]: got %0d expected %0d", i-2, output_signal, exp_p[i-2]);
            else n_pass++;
          end else begin
            if (output_signal !== 16'(exp_n[i-2]))
              $display("FAIL sat neg[%0d]: got %0d expected %0d", i-2, output_signal, exp_n[i-2]);
            else n_pass++;
          end
        end
      end
      idle();
    end
  endtask

  task automatic test_gaps();
    int pat  [4] = '{1, 0, 1, 1};
    int samp [4] = '{3, 99, 4, 5};
    int exp_v[6] = '{0, 0, 1, 0, 1, 1};
    int exp_o[6] = '{0, 0, 3, 3, 7, 12};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin valid_in = 1'(pat[i]); input_signal = 16'(samp[i]); end
      else begin valid_in = 1'b0; input_signal = '0; end
      tick();
      n_checks++;
      if (valid_out !== 1'(exp_v[i]))
        $display("FAIL gap valid[%0d]: got %b expected %0d", i, valid_out, exp_v[i]);
      else n_pass++;
      n_checks++;
      if (output_signal !== 16'(exp_o[i]))
        $display("FAIL gap out[%0d]: got %0d expected %0d", i, output_signal, exp_o[i]);
      else n_pass++;
    end
  endtask

  // Flush one cycle after sample 3, with a coefficient write on the flush edge.
  task automatic test_flush();
    int vin  [8] = '{1, 1, 1, 0, 1, 1, 0, 0};
    int samp [8] = '{1, 2, 3, 0, 9, 1, 0, 0};
    int fl   [8] = '{0, 0, 0, 1, 0, 0, 0, 0};
    int exp_v[8] = '{0, 0, 1, 1, 0, 0, 1, 1};
    int exp_o[8] = '{0, 0, 1, 3, 3, 3, 9, 28};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      valid_in = 1'(vin[i]); input_signal = 16'(samp[i]); flush = 1'(fl[i]);
      coef_we = (i == 3); coef_addr = 2'd1; coef_data = 16'sd3;
      tick();
      n_checks++;
      if (valid_out !== 1'(exp_v[i]))
        $display("FAIL flush valid[%0d]: got %b expected %0d", i, valid_out, exp_v[i]);
      else n_pass++;
      n_checks++;
      if (output_signal !== 16'(exp_o[i]))
        $display("FAIL flush out[%0d]: got %0d expected %0d", i, output_signal, exp_o[i]);
      else n_pass++;
    end
    idle();
  endtask

  // flush together with valid_in drops the sample and kills the one in flight.
  task automatic test_flush_priority();
    int vin  [5] = '{1, 1, 1, 0, 0};
    int samp [5] = '{4, 100, 2, 0, 0};
    int fl   [5] = '{0, 1, 0, 0, 0};
    int exp_v[5] = '{0, 0, 0, 0, 1};
    int exp_o[5] = '{0, 0, 0, 0, 2};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      valid_in = 1'(vin[i]); input_signal = 16'(samp[i]); flush = 1'(fl[i]);
      tick();
      n_checks++;
      if (valid_out !== 1'(exp_v[i]))
        $display("FAIL flprio valid[%0d]: got %b expected %0d", i, valid_out, exp_v[i]);
      else n_pass++;
      n_checks++;
      if (output_signal !== 16'(exp_o[i]))
        $display("FAIL flprio out[%0d]: got %0d expected %0d", i, output_signal, exp_o[i]);
      else n_pass++;
    end
    idle();
  endtask

  // Coefficient written on the accepting edge applies to that sample.
  task automatic test_coef_midstream();
    int samp [4] = '{3, 1, 0, 0};
    int cwe  [4] = '{1, 1, 0, 0};
    int cad  [4] = '{0, 1, 0, 0};
    int cdat [4] = '{5, -2, 0, 0};
    int exp_v[4] = '{0, 0, 1, 1};
    int exp_o[4] = '{0, 0, 15, -1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      valid_in = (i < 2); input_signal = 16'(samp[i]);
      coef_we = 1'(cwe[i]); coef_addr = 2'(cad[i]); coef_data = 16'(cdat[i]);
      tick();
      n_checks++;
      if (valid_out !== 1'(exp_v[i]))
        $display("FAIL coefwr valid[%0d]: got %b expected %0d", i, valid_out, exp_v[i]);
      else n_pass++;
      n_checks++;
      if (output_signal !== 16'(exp_o[i]))
        $display("FAIL coefwr out[%0d]: got %0d expected %0d", i, output_signal, exp_o[i]);
      else n_pass++;
    end
    idle();
  endtask

  task automatic test_reset_midstream();
    int vin  [8] = '{1, 1, 1, 0, 0, 1, 0, 0};
    int samp [8] = '{1, 2, 3, 0, 0, 2, 0, 0};
    int exp_v[8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    int exp_o[8] = '{0, 0, 0, 0, 0, 0, 0, 2};
    do_reset();
    write_coef(0, 5);
    for (int i = 0; i < 8; i++) begin
      valid_in = 1'(vin[i]); input_signal = 16'(samp[i]); rst = (i == 2);
      tick();
      n_checks++;
      if (valid_out !== 1'(exp_v[i]))
        $display("FAIL rstmid valid[%0d]: got %b expected %0d", i, valid_out, exp_v[i]);
      else n_pass++;
      n_checks++;
      if (output_signal !== 16'(exp_o[i]))
        $display("FAIL rstmid out[%0d]: got %0d expected %0d", i, output_signal, exp_o[i]);
      else n_pass++;
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_running_sum();
    test_difference();
    test_saturation();
    test_gaps();
    test_flush();
    test_flush_priority();
    test_coef_midstream();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
